// File: rtl/harris_pkg.sv
// Shared types and defaults for the Harris corner extractor: FSM state encoding,
// default score width and the default-geometry corner event layout.
package harris_pkg;

  localparam int unsigned HARRIS_SCORE_W = 32;
  localparam int unsigned HARRIS_COORD_W = 12;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StActive = 1'b1
  } harris_state_e;

  typedef struct packed {
    logic [HARRIS_COORD_W-1:0] x;
    logic [HARRIS_COORD_W-1:0] y;
    logic [HARRIS_SCORE_W-1:0] score;
  } corner_evt_t;

endpackage

// File: rtl/harris_corner_extractor_if.sv
// Corner event stream: FIFO head plus valid/ready handshake towards the consumer.
interface harris_corner_extractor_if #(
  parameter int unsigned COORD_W = 12,
  parameter int unsigned SCORE_W = harris_pkg::HARRIS_SCORE_W
);
  logic [COORD_W-1:0] corner_x;
  logic [COORD_W-1:0] corner_y;
  logic [SCORE_W-1:0] corner_score;
  logic               corner_valid;
  logic               corner_ready;

  modport master (
    output corner_x,
    output corner_y,
    output corner_score,
    output corner_valid,
    input  corner_ready
  );

  modport slave (
    input  corner_x,
    input  corner_y,
    input  corner_score,
    input  corner_valid,
    output corner_ready
  );
endinterface

// File: rtl/corner_fifo.sv
// Synchronous first-word-fall-through event queue; head reads as zero while empty.
module corner_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 56
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);
  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_q, rd_q;
  logic             empty;
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign valid_o = !empty;
  assign data_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/harris_corner_extractor.sv
// Raster-order non-maximum suppression on Harris scores; queues {x, y, score}
// corner events and reports per-frame count, overflow and end-of-frame.
module harris_corner_extractor
  import harris_pkg::*;
#(
  parameter int unsigned SCORE_W    = HARRIS_SCORE_W,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned NMS_K      = 3,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned COORD_W    = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SCORE_W-1:0]        score,
  input  logic                      score_valid,
  input  logic                      sof,
  input  logic [SCORE_W-1:0]        threshold,
  input  logic                      enable,
  harris_corner_extractor_if.master corner_io,
  output logic                      frame_done,
  output logic [15:0]               corner_count,
  output logic                      overflow
);
  localparam int unsigned R    = (NMS_K - 1) / 2;
  localparam int unsigned XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned EvtW = 2 * COORD_W + SCORE_W;

  typedef logic [NMS_K-1:0][SCORE_W-1:0] col_t;

  harris_state_e      state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               en_q, en_d;
  logic [15:0]        count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               done1_q, done1_d, done_q, done_d;

  logic               accept, last_pix, is_max, hit, pop, push_ok;
  logic               fifo_full, fifo_valid;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic [XW-1:0]      xi;
  logic [EvtW-1:0]    evt, head;

  // Line buffers: lb_q[0] holds the previous line, lb_q[k] the line k+1 above.
  logic [SCORE_W-1:0] lb_q [NMS_K-1][IMG_W];
  col_t               cols_q [NMS_K-1];
  col_t               cur_col;
  col_t               win [NMS_K];

  assign accept   = score_valid && (sof || (state_q == StActive));
  assign cur_x    = sof ? '0 : x_q;
  assign cur_y    = sof ? '0 : y_q;
  assign xi       = cur_x[XW-1:0];
  assign last_pix = (cur_x == COORD_W'(IMG_W - 1)) && (cur_y == COORD_W'(IMG_H - 1));

  // Row 0 of a column is the oldest line, row NMS_K-1 the incoming pixel.
  always_comb begin
    cur_col = '0;
    cur_col[NMS_K-1] = score;
    for (int unsigned k = 0; k < NMS_K - 1; k++) begin
      cur_col[NMS_K-2-k] = lb_q[k][xi];
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NMS_K - 1; c++) begin
      win[c] = cols_q[c];
    end
    win[NMS_K-1] = cur_col;
  end

  // Earlier neighbours may tie the centre, later ones must be strictly smaller.
  always_comb begin
    is_max = win[R][R] > threshold;
    for (int unsigned r = 0; r < NMS_K; r++) begin
      for (int unsigned c = 0; c < NMS_K; c++) begin
        if ((r < R) || ((r == R) && (c < R))) begin
          if (win[c][r] > win[R][R]) is_max = 1'b0;
        end else if (!((r == R) && (c == R))) begin
          if (win[c][r] >= win[R][R]) is_max = 1'b0;
        end
      end
    end
  end

  assign hit = accept && en_q && is_max &&
               (cur_x >= COORD_W'(2 * R)) && (cur_y >= COORD_W'(2 * R));
  assign evt     = {cur_x - COORD_W'(R), cur_y - COORD_W'(R), win[R][R]};
  assign pop     = fifo_valid && corner_io.corner_ready;
  assign push_ok = hit && (!fifo_full || pop);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    en_d    = en_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    done1_d = 1'b0;
    done_d  = done1_q;
    if (accept) begin
      if (sof) begin
        state_d = StActive;
        en_d    = enable;
        count_d = '0;
        ovf_d   = 1'b0;
      end
      if (last_pix) begin
        state_d = StIdle;
        x_d     = '0;
        y_d     = '0;
        done1_d = 1'b1;
      end else if (cur_x == COORD_W'(IMG_W - 1)) begin
        x_d = '0;
        y_d = cur_y + COORD_W'(1);
      end else begin
        x_d = cur_x + COORD_W'(1);
        y_d = cur_y;
      end
    end
    if (push_ok && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
    if (hit && !push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      en_q    <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      done1_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      en_q    <= en_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      done1_q <= done1_d;
      done_q  <= done_d;
    end
  end

  // Window storage is pure datapath; stale contents never reach an evaluated window.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      lb_q[0][xi] <= score;
      for (int unsigned k = 1; k < NMS_K - 1; k++) begin
        lb_q[k][xi] <= lb_q[k-1][xi];
      end
      for (int unsigned c = 0; c < NMS_K - 2; c++) begin
        cols_q[c] <= cols_q[c+1];
      end
      cols_q[NMS_K-2] <= cur_col;
    end
  end

  corner_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EvtW)
  ) u_corner_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push_ok),
    .data_i  (evt),
    .pop_i   (pop),
    .data_o  (head),
    .valid_o (fifo_valid),
    .full_o  (fifo_full)
  );

  assign corner_io.corner_x     = head[EvtW-1 -: COORD_W];
  assign corner_io.corner_y     = head[SCORE_W +: COORD_W];
  assign corner_io.corner_score = head[SCORE_W-1:0];
  assign corner_io.corner_valid = fifo_valid;

  assign frame_done   = done_q;
  assign corner_count = count_q;
  assign overflow     = ovf_q;
endmodule

// File: tb/tb_harris_corner_extractor.sv
// Directed bench for harris_corner_extractor on an 8x6 image, 3x3 NMS, 4-deep queue.
module tb_harris_corner_extractor;
  import harris_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned H = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] score;
  logic        score_valid;
  logic        sof;
  logic [31:0] threshold;
  logic        enable;
  logic        frame_done;
  logic [15:0] corner_count;
  logic        overflow;

  harris_corner_extractor_if #(.COORD_W(12), .SCORE_W(32)) cif ();

  harris_corner_extractor #(
    .SCORE_W    (32),
    .IMG_W      (W),
    .IMG_H      (H),
    .NMS_K      (3),
    .FIFO_DEPTH (4),
    .COORD_W    (12)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .score        (score),
    .score_valid  (score_valid),
    .sof          (sof),
    .threshold    (threshold),
    .enable       (enable),
    .corner_io    (cif),
    .frame_done   (frame_done),
    .corner_count (corner_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          fd_cnt = 0;
  corner_evt_t ev_q[$];
  logic [31:0] img [W*H];

  always @(negedge clk) begin
    if (rst_n && cif.corner_valid && cif.corner_ready)
      ev_q.push_back(corner_evt_t'{x: cif.corner_x, y: cif.corner_y, score: cif.corner_score});
    if (frame_done) fd_cnt++;
  end

  function automatic corner_evt_t mk(input int x, input int y, input int s);
    corner_evt_t e;
    e.x = 12'(x);
    e.y = 12'(y);
    e.score = 32'(s);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < W * H; i++) img[i] = 32'd0;
  endtask

  task automatic set_px(input int x, input int y, input int v);
    img[y*W + x] = 32'(v);
  endtask

  task automatic send_range(input int first, input int last, input bit with_sof);
    for (int n = first; n <= last; n++) begin
      @(negedge clk);
      score       = img[n];
      score_valid = 1'b1;
      sof         = with_sof && (n == first);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      score_valid = 1'b0;
      sof         = 1'b0;
    end
  endtask

  function automatic logic [63:0] head_word();
    return 64'({cif.corner_x, cif.corner_y, cif.corner_score});
  endfunction

  initial begin
    rst_n            = 1'b0;
    score            = '0;
    score_valid      = 1'b0;
    sof              = 1'b0;
    threshold        = 32'd50;
    enable           = 1'b1;
    cif.corner_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst valid", 64'(cif.corner_valid), 64'd0);
    check("rst done", 64'(frame_done), 64'd0);
    check("rst count", 64'(corner_count), 64'd0);
    check("rst ovf", 64'(overflow), 64'd0);
    check("rst x", 64'(cif.corner_x), 64'd0);
    check("rst y", 64'(cif.corner_y), 64'd0);
    check("rst score", 64'(cif.corner_score), 64'd0);
    rst_n = 1'b1;

    // Reset mid-frame with queued events, then the rest of the frame without sof
    clear_img();
    set_px(1, 1, 100); set_px(3, 1, 100); set_px(5, 1, 100);
    set_px(1, 3, 100); set_px(3, 3, 100); set_px(5, 3, 100);
    cif.corner_ready = 1'b0;
    send_range(0, 23, 1'b1);
    idle(1);
    check("s33 pre valid", 64'(cif.corner_valid), 64'd1);
    check("s33 pre count", 64'(corner_count), 64'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check("s33 valid", 64'(cif.corner_valid), 64'd0);
    check("s33 count", 64'(corner_count), 64'd0);
    check("s33 ovf", 64'(overflow), 64'd0);
    rst_n            = 1'b1;
    cif.corner_ready = 1'b1;
    ev_q.delete();
    fd_cnt = 0;
    send_range(24, 47, 1'b0);
    idle(4);
    check("s33 events", 64'(ev_q.size()), 64'd0);
    check("s33 count post", 64'(corner_count), 64'd0);
    check("s33 done", 64'(fd_cnt), 64'd0);

    // Single isolated peak, frame_done timing
    clear_img();
    set_px(3, 2, 100);
    ev_q.delete();
    fd_cnt = 0;
    send_range(0, W*H-1, 1'b1);
    idle(1);
    check("s34 done c+1", 64'(frame_done), 64'd0);
    idle(1);
    check("s34 done c+2", 64'(frame_done), 64'd1);
    check("s34 count", 64'(corner_count), 64'd1);
    idle(1);
    check("s34 done c+3", 64'(frame_done), 64'd0);
    idle(2);
    check("s34 events", 64'(ev_q.size()), 64'd1);
    if (ev_q.size() > 0) check("s34 evt", 64'(ev_q[0]), 64'(mk(3, 2, 100)));
    check("s34 done cnt", 64'(fd_cnt), 64'd1);

    // Border peaks, score equal to threshold, and disabled frame
    clear_img();
    set_px(0, 2, 100); set_px(7, 5, 100);
    ev_q.delete();
    send_range(0, W*H-1, 1'b1);
    idle(4);
    check("s35 border events", 64'(ev_q.size()), 64'd0);
    check("s35 border count", 64'(corner_count), 64'd0);
    clear_img();
    set_px(3, 2, 50);
    send_range(0, W*H-1, 1'b1);
    idle(4);
    check("s35 thr events", 64'(ev_q.size()), 64'd0);
    check("s35 thr count", 64'(corner_count), 64'd0);
    clear_img();
    set_px(3, 2, 100);
    enable = 1'b0;
    send_range(0, W*H-1, 1'b1);
    enable = 1'b1;
    idle(4);
    check("s35 disabled", 64'(ev_q.size()), 64'd0);

    // Plateau: last in raster order wins
    clear_img();
    set_px(3, 2, 100); set_px(4, 2, 100);
    ev_q.delete();
    send_range(0, W*H-1, 1'b1);
    idle(4);
    check("s36 events", 64'(ev_q.size()), 64'd1);
    if (ev_q.size() > 0) check("s36 evt", 64'(ev_q[0]), 64'(mk(4, 2, 100)));
    check("s36 count", 64'(corner_count), 64'd1);

    // Six peaks into a 4-deep queue with the consumer stalled
    clear_img();
    set_px(1, 1, 100); set_px(3, 1, 100); set_px(5, 1, 100);
    set_px(1, 3, 100); set_px(3, 3, 100); set_px(5, 3, 100);
    cif.corner_ready = 1'b0;
    ev_q.delete();
    send_range(0, W*H-1, 1'b1);
    idle(3);
    check("s37 ovf", 64'(overflow), 64'd1);
    check("s37 count", 64'(corner_count), 64'd4);
    check("s37 valid", 64'(cif.corner_valid), 64'd1);
    check("s37 head", head_word(), 64'(mk(1, 1, 100)));
    idle(3);
    check("s37 head hold", head_word(), 64'(mk(1, 1, 100)));
    @(posedge clk);
    #1 cif.corner_ready = 1'b1;
    idle(6);
    check("s37 events", 64'(ev_q.size()), 64'd4);
    if (ev_q.size() == 4) begin
      check("s37 evt0", 64'(ev_q[0]), 64'(mk(1, 1, 100)));
      check("s37 evt1", 64'(ev_q[1]), 64'(mk(3, 1, 100)));
      check("s37 evt2", 64'(ev_q[2]), 64'(mk(5, 1, 100)));
      check("s37 evt3", 64'(ev_q[3]), 64'(mk(1, 3, 100)));
    end
    check("s37 drained", 64'(cif.corner_valid), 64'd0);
    check("s37 ovf sticky", 64'(overflow), 64'd1);

    // Aborted partial frame (stale plateau data) followed by a full frame
    clear_img();
    for (int i = 0; i < 20; i++) img[i] = 32'd90;
    ev_q.delete();
    fd_cnt = 0;
    send_range(0, 19, 1'b1);
    clear_img();
    set_px(2, 2, 100);
    send_range(0, W*H-1, 1'b1);
    idle(5);
    check("s38 events", 64'(ev_q.size()), 64'd1);
    if (ev_q.size() > 0) check("s38 evt", 64'(ev_q[0]), 64'(mk(2, 2, 100)));
    check("s38 done cnt", 64'(fd_cnt), 64'd1);
    check("s38 count", 64'(corner_count), 64'd1);
    check("s38 ovf", 64'(overflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/harris_corner_extractor.md
HARRIS_CORNER_EXTRACTOR -- requirements
Module: harris_corner_extractor

Interface
REQ-001 SHALL have parameter SCORE_W, default 32: unsigned Harris score width.
REQ-002 SHALL have parameter IMG_W, default 640: pixels per line.
REQ-003 SHALL have parameter IMG_H, default 480: lines per frame.
REQ-004 SHALL have parameter NMS_K, default 3: non-max-suppression window size; legal values are 3 and 5; R=(NMS_K-1)/2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16: corner event queue depth, a power of 2.
REQ-006 SHALL have parameter COORD_W, default 12: width of the x and y coordinates.
REQ-007 SHALL have these ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- score  in  SCORE_W  Harris score in raster order.
- score_valid  in  1  score is present this cycle.
- sof  in  1  first pixel of a frame; qualified by score_valid.
- threshold  in  SCORE_W  unsigned corner threshold.
- enable  in  1  event generation enable; sampled at sof.
- corner_x  out  COORD_W  x of the head event.
- corner_y  out  COORD_W  y of the head event.
- corner_score  out  SCORE_W  score of the head event.
- corner_valid  out  1  event FIFO is not empty.
- corner_ready  in  1  consumer pops the head event.
- frame_done  out  1  one-cycle end-of-frame pulse.
- corner_count  out  16  events accepted this frame; saturates at 0xFFFF.
- overflow  out  1  sticky; an event was dropped this frame.

Function
REQ-008 SHALL implement a two-state FSM, IDLE and ACTIVE; reset enters IDLE.
REQ-009 SHALL ignore a score_valid pixel without sof while in IDLE.
REQ-010 SHALL, on score_valid&&sof in either state:
- treat that pixel as (0,0);
- enter ACTIVE;
- clear corner_count and overflow;
- latch enable.
REQ-011 SHALL, in ACTIVE, advance x on each score_valid; x wraps at IMG_W-1 to 0 and increments y.
REQ-012 SHALL return to IDLE after accepting pixel (IMG_W-1, IMG_H-1).
REQ-013 SHALL hold NMS_K-1 line buffers of IMG_W scores each, forming an NMS_K x NMS_K window.
REQ-014 SHALL evaluate centre (x-R, y-R) in the cycle pixel (x,y) is accepted, and only when x>=2R and y>=2R.
REQ-015 SHALL never evaluate centres within R of any border.
REQ-016 SHALL declare a corner when all of the following hold:
- centre > threshold (strict);
- centre >= every window neighbour earlier in raster order;
- centre > every window neighbour later in raster order.
On a plateau, the last pixel in raster order wins.
REQ-017 SHALL use unsigned comparison at full SCORE_W width.
REQ-018 SHALL push the event {x, y, score} into the FIFO on the clock edge after evaluation, only when the latched enable=1.
REQ-019 SHALL accept a push when the FIFO is not full, or when a pop occurs in the same cycle.
REQ-020 SHALL otherwise drop the event and set overflow; corner_count is not incremented for a dropped event.
REQ-021 SHALL increment corner_count on the same edge as each accepted push.
REQ-022 SHALL pop the FIFO when corner_valid&&corner_ready.
REQ-023 SHALL keep the head event stable while corner_valid=1 and corner_ready=0.
REQ-024 SHALL assert frame_done for exactly one cycle, two cycles after the final pixel is accepted; corner_count is final in that cycle.
REQ-025 SHALL, on a mid-frame sof, abort the current frame:
- coordinates restart at (0,0);
- FIFO contents are kept;
- no frame_done is issued for the aborted frame.
REQ-026 SHALL ignore stale line-buffer data after an abort; REQ-014 guarantees every evaluated window lies wholly in the current frame.
REQ-027 SHALL tolerate score_valid gaps; state holds while score_valid=0.

Reset
REQ-028 SHALL, while reset=0 at a clock edge, bring the block to:
- FSM in IDLE;
- FIFO emptied;
- corner_valid=0, frame_done=0, corner_count=0, overflow=0;
- corner_x, corner_y and corner_score all 0.
REQ-029 SHALL leave line-buffer contents unreset.
REQ-030 SHALL abort a frame in progress when reset is asserted mid-frame.

Structure
REQ-031 SHALL import from package harris_pkg:
- the FSM state enum;
- the default SCORE_W;
- the corner event struct {x, y, score}.
REQ-032 SHALL instantiate exactly one sub-module, corner_fifo: synchronous, parametrised by depth and event width, with a first-word-fall-through head.

Verification
Bench parameters for all scenarios: IMG_W=8, IMG_H=6, NMS_K=3, FIFO_DEPTH=4, threshold=50, corner_ready=1 unless stated.
REQ-033 Reset asserted mid-frame -> next cycle corner_valid=0, corner_count=0, overflow=0; subsequent pixels without sof produce no event.
REQ-034 All scores 0 except 100 at (3,2) -> exactly one event (3,2,100); frame_done 2 cycles after the last pixel; corner_count=1.
REQ-035 Peaks of 100 at (0,2) and (7,5); separately, score=50 at (3,2) -> no events; corner_count=0.
REQ-036 Scores 100 at both (3,2) and (4,2) -> single event (4,2,100).
REQ-037 Six isolated peaks of 100 at (1,1),(3,1),(5,1),(1,3),(3,3),(5,3) with corner_ready=0 -> four events held in order; overflow=1; corner_count=4.
REQ-038 sof, then 20 pixels, then sof plus a full frame with one peak of 100 at (2,2) -> one event (2,2,100); one frame_done; corner_count=1.
